// File: rtl/png_game_pkg.sv
// Shared types and constants for the Pong game-flow sequencer.
package png_game_pkg;

    localparam int unsigned SCORE_W       = 4;
    localparam int unsigned WIN_SCORE_DEF = 11;

    typedef enum logic [1:0] {
        ATTRACT   = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    // Saturating increment: a score register parked at full scale stays there.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/png_serve_timer.sv
// Post-miss serve delay: counts frame ticks and flags the tick that releases the ball.
module png_serve_timer #(
    parameter int unsigned SERVE_FRAMES = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic tick,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick && !clear && (cnt == CNT_W'(SERVE_FRAMES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (clear || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/png_game_seq.sv
// Pong game-flow sequencer: attract/serve/play/game-over control, scores and serve direction.
module png_game_seq
    import png_game_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = png_game_pkg::WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         coin,
    input  logic         frame_tick,
    input  logic         miss_l,
    input  logic         miss_r,
    output logic         attract,
    output logic         ball_en,
    output logic         serve_dir,
    output logic [3:0]   score_l,
    output logic [3:0]   score_r,
    output logic         game_over
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    game_state_t        state;
    logic               coin_s1, coin_s2, coin_d;
    logic               coin_rise;
    logic               serve_clear;
    logic               serve_done;
    logic [SCORE_W-1:0] next_l, next_r;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            coin_s1 <= 1'b0;
            coin_s2 <= 1'b0;
            coin_d  <= 1'b0;
        end else begin
            coin_s1 <= coin;
            coin_s2 <= coin_s1;
            coin_d  <= coin_s2;
        end
    end

    assign coin_rise   = coin_s2 & ~coin_d;
    assign next_l      = score_inc(score_l);
    assign next_r      = score_inc(score_r);
    // Counter is held clear outside SERVE, so a tick on the entry edge is never counted.
    assign serve_clear = (state != SERVE);

    png_serve_timer #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .CNT_W        (CNT_W)
    ) u_serve_timer (
        .clk   (clk),
        .clr   (clr),
        .clear (serve_clear),
        .tick  (frame_tick),
        .done  (serve_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ATTRACT;
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= 1'b0;
            attract   <= 1'b1;
            ball_en   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                ATTRACT, GAME_OVER: begin
                    if (coin_rise) begin
                        state     <= SERVE;
                        score_l   <= '0;
                        score_r   <= '0;
                        serve_dir <= 1'b0;
                        attract   <= 1'b0;
                        ball_en   <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                SERVE: begin
                    if (serve_done) begin
                        state   <= PLAY;
                        ball_en <= 1'b1;
                    end
                end
                PLAY: begin
                    // miss_l wins a tie; the simultaneous miss_r is dropped.
                    if (miss_l || miss_r) begin
                        ball_en <= 1'b0;
                        if (miss_l) begin
                            score_r   <= next_r;
                            serve_dir <= 1'b0;
                        end else begin
                            score_l   <= next_l;
                            serve_dir <= 1'b1;
                        end
                        if ((miss_l && next_r == WIN) || (!miss_l && next_l == WIN)) begin
                            state     <= GAME_OVER;
                            attract   <= 1'b1;
                            game_over <= 1'b1;
                        end else begin
                            state <= SERVE;
                        end
                    end
                end
                default: begin
                    state     <= ATTRACT;
                    attract   <= 1'b1;
                    ball_en   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
